// File: rtl/control_fsm.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback sequencing for an RV32I subset.
// Latency: 1 cycle per state, FETCH and MEM stretch until mem_ready; outputs are combinational from state.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal instructions halt instead of retiring as NOPs.
module control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [3:0]  alucontrol,
  output logic [1:0]  alusrc_a,
  output logic [1:0]  alusrc_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        reg_write,
  output logic        wb_src,
  output logic        halted
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] instr;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       legal;
  logic       br_taken;
  logic [3:0] exec_alu;
  logic [1:0] exec_a;
  logic [1:0] exec_b;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];

  // Register indices and immediates are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7_5, input logic is_r);
    case (f3)
      3'b000:  alu_op = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // BEQ/BNE compare via SUB, the others via SLT(U); funct3[0] inverts the sense.
  assign br_taken = funct3[2] ? (zero == funct3[0]) : (zero != funct3[0]);

  always_comb begin
    legal    = 1'b1;
    exec_alu = ALU_ADD;
    exec_a   = 2'd0;
    exec_b   = 2'd1;
    case (opcode)
      OP_R: begin
        exec_b   = 2'd0;
        exec_alu = alu_op(funct3, funct7_5, 1'b1);
      end
      OP_I:         exec_alu = alu_op(funct3, funct7_5, 1'b0);
      OP_LW, OP_SW: exec_alu = ALU_ADD;
      OP_LUI:       exec_a   = 2'd2;
      OP_BR: begin
        exec_b = 2'd0;
        case (funct3[2:1])
          2'b00:   exec_alu = ALU_SUB;
          2'b10:   exec_alu = ALU_SLT;
          2'b11:   exec_alu = ALU_SLTU;
          default: legal    = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      instr <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && mem_ready) begin
        instr <= instr_in;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_FETCH;
      S_FETCH: if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        if (legal) begin
          next_state = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          next_state = S_HALT;
`else
          next_state = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEM;
        else if (opcode == OP_BR)               next_state = S_FETCH;
        else                                    next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready) next_state = (opcode == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:    next_state = S_FETCH;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    alusrc_a   = 2'd0;
    alusrc_b   = 2'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    wb_src     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrc_a = 2'd1;
        alusrc_b = 2'd2;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        alucontrol = exec_alu;
        alusrc_a   = exec_a;
        alusrc_b   = exec_b;
        if (opcode == OP_BR && br_taken) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
      end
      S_MEM: begin
        alucontrol = exec_alu;
        alusrc_a   = exec_a;
        alusrc_b   = exec_b;
        mem_read   = (opcode == OP_LW);
        mem_write  = (opcode == OP_SW);
      end
      // ALU selects stay applied so an un-registered ALU result is still valid at writeback.
      S_WB: begin
        alucontrol = exec_alu;
        alusrc_a   = exec_a;
        alusrc_b   = exec_b;
        reg_write  = 1'b1;
        wb_src     = (opcode == OP_LW);
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT: halted = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle stimulus and expected outputs queued, then popped and compared.
module tb_control_fsm;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;

  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BGEU = 32'h0020F463;
  localparam logic [31:0] I_BBAD = 32'h0020A463;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_SRAI = 32'h4020D093;
  localparam logic [31:0] I_SRL  = 32'h0020D133;
  localparam logic [31:0] I_JUNK = 32'hFFFFFFFF;

  // Vector order: alucontrol, alusrc_a, alusrc_b, mem_read, mem_write, pc_write, pc_src, ir_write, reg_write, wb_src, halted
  localparam logic [15:0] V_ZERO       = 16'h0000;
  localparam logic [15:0] V_FETCH_WAIT = {ALU_ADD, 2'd1, 2'd2, 8'b1000_0000};
  localparam logic [15:0] V_FETCH_DONE = {ALU_ADD, 2'd1, 2'd2, 8'b1010_1000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic [3:0]  alucontrol;
  logic [1:0]  alusrc_a, alusrc_b;
  logic        mem_read, mem_write, pc_write, pc_src, ir_write, reg_write, wb_src, halted;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] exp;
    logic        mr;
    logic        z;
    logic [31:0] instr;
    string       tag;
  } rec_t;

  rec_t sb[$];

  control_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .mem_ready(mem_ready), .zero(zero),
    .alucontrol(alucontrol), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .mem_read(mem_read), .mem_write(mem_write), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .reg_write(reg_write), .wb_src(wb_src), .halted(halted)
  );

  assign obs = {alucontrol, alusrc_a, alusrc_b, mem_read, mem_write, pc_write, pc_src,
                ir_write, reg_write, wb_src, halted};

  always #5 clk = ~clk;

  function automatic logic [15:0] ov(input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
                                     input logic rw, input logic wb);
    return {alu, a, b, 4'b0000, 1'b0, rw, wb, 1'b0};
  endfunction

  task automatic push(input logic [15:0] e, input logic mr, input logic z,
                      input logic [31:0] ins, input string tag);
    rec_t r;
    r.exp = e; r.mr = mr; r.z = z; r.instr = ins; r.tag = tag;
    sb.push_back(r);
  endtask

  // Called at posedge+1; leaves the DUT in its IDLE cycle at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; instr_in = I_SUB;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== V_ZERO) begin
        errors++; $display("FAIL reset_hold: got %h expected %h", obs, V_ZERO);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(V_ZERO, 1, 0, I_SUB, "idle_after_reset");
    push(V_FETCH_DONE, 1, 0, I_SUB, "first_fetch");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r_type();
    do_reset();
    push(V_ZERO, 1, 0, I_SUB, "r_idle");
    push(V_FETCH_DONE, 1, 0, I_SUB, "r_fetch");
    push(V_ZERO, 1, 0, 32'hDEADBEEF, "r_decode");
    push(ov(ALU_SUB, 2'd0, 2'd0, 0, 0), 1, 0, 32'hDEADBEEF, "r_exec_sub");
    push(ov(ALU_SUB, 2'd0, 2'd0, 1, 0), 1, 0, 32'hDEADBEEF, "r_wb");
    push(V_FETCH_DONE, 1, 0, I_SUB, "r_refetch_4cyc");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic [15:0] v_mem;
    v_mem = {ALU_ADD, 2'd0, 2'd1, 8'b1000_0000};
    do_reset();
    push(V_ZERO, 0, 0, I_JUNK, "lw_idle");
    push(V_FETCH_WAIT, 0, 0, I_JUNK, "lw_fetch_wait");
    push(V_FETCH_DONE, 1, 0, I_LW, "lw_fetch");
    push(V_ZERO, 0, 0, I_JUNK, "lw_decode");
    push(ov(ALU_ADD, 2'd0, 2'd1, 0, 0), 0, 0, I_JUNK, "lw_exec");
    for (int i = 0; i < 3; i++) push(v_mem, 0, 0, I_JUNK, "lw_mem_wait");
    push(v_mem, 1, 0, I_JUNK, "lw_mem_done");
    push(ov(ALU_ADD, 2'd0, 2'd1, 1, 1), 0, 0, I_JUNK, "lw_wb_load");
    push(V_FETCH_WAIT, 0, 0, I_JUNK, "lw_back_to_fetch");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [15:0] taken_sub, taken_slt;
    taken_sub = {ALU_SUB, 2'd0, 2'd0, 8'b0011_0000};
    taken_slt = {ALU_SLT, 2'd0, 2'd0, 8'b0011_0000};
    do_reset();
    push(V_ZERO, 1, 0, I_BEQ, "br_idle");
    push(V_FETCH_DONE, 1, 0, I_BEQ, "beq_fetch");
    push(V_ZERO, 0, 1, I_JUNK, "beq_decode");
    push(taken_sub, 0, 1, I_JUNK, "beq_taken");
    push(V_FETCH_DONE, 1, 0, I_BEQ, "beq2_fetch");
    push(V_ZERO, 0, 0, I_JUNK, "beq2_decode");
    push(ov(ALU_SUB, 2'd0, 2'd0, 0, 0), 1, 0, I_JUNK, "beq_not_taken");
    push(V_FETCH_DONE, 1, 0, I_BLT, "blt_fetch");
    push(V_ZERO, 0, 0, I_JUNK, "blt_decode");
    push(taken_slt, 0, 0, I_JUNK, "blt_taken");
    push(V_FETCH_DONE, 1, 0, I_BGEU, "bgeu_fetch");
    push(V_ZERO, 0, 0, I_JUNK, "bgeu_decode");
    push(ov(ALU_SLTU, 2'd0, 2'd0, 0, 0), 0, 0, I_JUNK, "bgeu_not_taken");
    push(V_FETCH_WAIT, 0, 0, I_JUNK, "br_back_to_fetch");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [15:0] v_halt;
    v_halt = 16'h0001;
    do_reset();
    push(V_ZERO, 1, 0, I_JUNK, "ill_idle");
    push(V_FETCH_DONE, 1, 0, I_JUNK, "ill_fetch");
    push(V_ZERO, 1, 0, I_ADDI, "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) push(v_halt, 1, 1, I_ADDI, "ill_halt_held");
`else
    push(V_FETCH_DONE, 1, 0, I_ADDI, "ill_nop_refetch");
    push(V_ZERO, 1, 0, I_JUNK, "ill_next_decode");
    push(ov(ALU_ADD, 2'd0, 2'd1, 0, 0), 1, 0, I_JUNK, "ill_next_exec");
    push(ov(ALU_ADD, 2'd0, 2'd1, 1, 0), 1, 0, I_JUNK, "ill_next_wb");
    push(V_FETCH_DONE, 1, 0, I_BBAD, "bbad_fetch");
    push(V_ZERO, 1, 0, I_JUNK, "bbad_decode");
    push(V_FETCH_WAIT, 0, 0, I_JUNK, "bbad_nop_refetch");
`endif
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    rst_n = 1'b0; #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL halt_cleared_by_reset: got %h expected %h", obs, V_ZERO); end
    do_reset();
    push(V_ZERO, 1, 0, I_BBAD, "bbad_idle");
    push(V_FETCH_DONE, 1, 0, I_BBAD, "bbad_fetch");
    push(V_ZERO, 1, 0, I_JUNK, "bbad_decode");
    push(v_halt, 1, 0, I_JUNK, "bbad_halt");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(V_ZERO, 0, 0, I_JUNK, "b2b_idle");
    push(V_FETCH_WAIT, 0, 0, I_JUNK, "b2b_fetch_wait");
    push(V_FETCH_DONE, 1, 0, I_ADDI, "addi_fetch");
    push(V_ZERO, 1, 0, I_JUNK, "addi_decode");
    push(ov(ALU_ADD, 2'd0, 2'd1, 0, 0), 1, 0, I_JUNK, "addi_exec");
    push(ov(ALU_ADD, 2'd0, 2'd1, 1, 0), 1, 0, I_JUNK, "addi_wb");
    push(V_FETCH_DONE, 1, 0, I_LUI, "lui_fetch");
    push(V_ZERO, 1, 0, I_JUNK, "lui_decode");
    push(ov(ALU_ADD, 2'd2, 2'd1, 0, 0), 1, 0, I_JUNK, "lui_exec");
    push(ov(ALU_ADD, 2'd2, 2'd1, 1, 0), 1, 0, I_JUNK, "lui_wb");
    push(V_FETCH_DONE, 1, 0, I_SRAI, "srai_fetch");
    push(V_ZERO, 1, 0, I_JUNK, "srai_decode");
    push(ov(ALU_SRA, 2'd0, 2'd1, 0, 0), 1, 0, I_JUNK, "srai_exec");
    push(ov(ALU_SRA, 2'd0, 2'd1, 1, 0), 1, 0, I_JUNK, "srai_wb");
    push(V_FETCH_DONE, 1, 0, I_SRL, "srl_fetch");
    push(V_ZERO, 1, 0, I_JUNK, "srl_decode");
    push(ov(ALU_SRL, 2'd0, 2'd0, 0, 0), 1, 0, I_JUNK, "srl_exec");
    push(ov(ALU_SRL, 2'd0, 2'd0, 1, 0), 1, 0, I_JUNK, "srl_wb");
    push(V_FETCH_WAIT, 0, 0, I_JUNK, "b2b_end_fetch");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [15:0] v_sw_mem;
    v_sw_mem = {ALU_ADD, 2'd0, 2'd1, 8'b0100_0000};
    do_reset();
    push(V_ZERO, 1, 0, I_SW, "sw_idle");
    push(V_FETCH_DONE, 1, 0, I_SW, "sw_fetch");
    push(V_ZERO, 1, 0, I_JUNK, "sw_decode_ignores_ready");
    push(ov(ALU_ADD, 2'd0, 2'd1, 0, 0), 1, 0, I_JUNK, "sw_exec_ignores_ready");
    push(v_sw_mem, 0, 0, I_JUNK, "sw_mem_wait");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
    #2;
    checks++;
    if (obs !== v_sw_mem) begin errors++; $display("FAIL sw_mem_still_held: got %h expected %h", obs, v_sw_mem); end
    rst_n = 1'b0; #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL sw_reset_drops_write: got %h expected %h", obs, V_ZERO); end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL sw_reset_ready_ignored: got %h expected %h", obs, V_ZERO); end
    @(posedge clk); #1;
    checks++;
    if (obs !== V_ZERO) begin errors++; $display("FAIL sw_reset_no_commit: got %h expected %h", obs, V_ZERO); end
    rst_n = 1'b1;
    push(V_ZERO, 0, 0, I_JUNK, "sw_restart_idle");
    push(V_FETCH_WAIT, 0, 0, I_JUNK, "sw_restart_fetch_wait");
    push(V_FETCH_DONE, 1, 0, I_SW, "sw_restart_fetch");
    while (sb.size() > 0) begin
      rec_t r = sb.pop_front();
      instr_in = r.instr; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      checks++;
      if (obs !== r.exp) begin errors++; $display("FAIL %s: got %h expected %h", r.tag, obs, r.exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_mid_sw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 instr_in  input  32  instruction word from memory; captured only on fetch completion.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-006 zero  input  1  ALU zero flag, valid in the same cycle as alucontrol.
REQ-007 alucontrol  output  4  ALU operation, using the ALU_* encodings in defines.svh.
REQ-008 alusrc_a  output  2  operand1 select: 0=rs1, 1=PC, 2=zero.
REQ-009 alusrc_b  output  2  operand2 select: 0=rs2, 1=imm, 2=constant 4.
REQ-010 mem_read, mem_write  output  1 each  memory request strobes.
REQ-011 pc_write  output  1  load PC.
REQ-012 pc_src  output  1  PC source: 0=PC+4, 1=branch target from the external adder.
REQ-013 ir_write, reg_write  output  1 each  instruction-register load and register-file write.
REQ-014 wb_src  output  1  writeback source: 0=ALU result, 1=load data.
REQ-015 halted  output  1  illegal-instruction halt indicator.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; encoded in one 3-bit register.
REQ-017 IDLE SHALL drive all outputs to 0 and go to FETCH after one cycle.
REQ-018 FETCH SHALL drive mem_read=1, alusrc_a=1, alusrc_b=2, alucontrol=ALU_ADD, and hold these until mem_ready=1; that cycle it SHALL also drive ir_write=1 and pc_write=1 (pc_src=0), capture instr_in, and go to DECODE.
REQ-019 FETCH with mem_ready=1 in its first cycle SHALL complete in one cycle; there is no minimum wait.
REQ-020 DECODE SHALL last one cycle with all strobes 0, then go to EXEC for supported opcodes and to the illegal path otherwise.
REQ-021 Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW), 1100011 (branch), 0110111 (LUI).
REQ-022 R/I ALU mapping by funct3: 000 ADD (R with funct7[5]=1: SUB), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (funct7[5]=1: SRA, both R and I), 110 OR, 111 AND.
REQ-023 Operand selects in EXEC: R uses a=0/b=0; I, LW and SW use a=0/b=1 with ALU_ADD; LUI uses a=2/b=1 with ALU_ADD.
REQ-024 Branch in EXEC: BEQ/BNE use ALU_SUB; BLT/BGE use ALU_SLT; BLTU/BGEU use ALU_SLTU.
REQ-025 Branch taken condition: BEQ when zero=1; BNE when zero=0; BLT/BLTU when zero=0; BGE/BGEU when zero=1.
REQ-026 A taken branch SHALL assert pc_write=1 and pc_src=1 in EXEC; every branch, taken or not, returns to FETCH.
REQ-027 Branch funct3 010 or 011 SHALL be treated as illegal.
REQ-028 EXEC SHALL go to WB for R, I and LUI, and to MEM for LW and SW.
REQ-029 MEM SHALL hold mem_read (LW) or mem_write (SW) with the address operands until mem_ready=1.
REQ-030 On MEM completion: LW goes to WB with wb_src=1; SW returns to FETCH.
REQ-031 WB SHALL assert reg_write=1 for exactly one cycle, then return to FETCH.
REQ-032 mem_read and mem_write SHALL never be asserted together; reg_write and pc_write SHALL never be asserted together.
REQ-033 mem_ready outside FETCH and MEM SHALL be ignored.

Reset
REQ-034 Asserting rst_n low in any state SHALL move the state immediately to IDLE and clear the captured instruction to 0.
REQ-035 While reset is held, all outputs SHALL be 0.
REQ-036 An access interrupted by reset SHALL produce no reg_write, pc_write or ir_write.

Configuration
REQ-037 Macro CTRL_ILLEGAL_TRAP_EN: when defined, an illegal instruction SHALL go DECODE->HALT.
REQ-038 HALT SHALL hold halted=1 with all other outputs 0, and only reset leaves it.
REQ-039 When CTRL_ILLEGAL_TRAP_EN is undefined, an illegal instruction SHALL go DECODE->FETCH as a NOP, and halted SHALL be tied to 0.

Verification
REQ-040 Reset release, mem_ready=1 held -> IDLE for 1 cycle, then FETCH with mem_read=1, ir_write=1, pc_write=1.
REQ-041 instr_in=0x40208133 (sub x2,x1,x2) -> EXEC alucontrol=ALU_SUB, a=0, b=0; WB reg_write=1; total 4 cycles FETCH-to-FETCH.
REQ-042 instr_in=0x0000A183 (lw), mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with wb_src=1.
REQ-043 instr_in=0x00208463 (beq) with zero=1 -> pc_write=1, pc_src=1 in EXEC; with zero=0 -> no pc_write in EXEC.
REQ-044 instr_in=0xFFFFFFFF -> with CTRL_ILLEGAL_TRAP_EN, halted=1 held until rst_n low; without it, next state FETCH and halted=0.
REQ-045 rst_n pulsed low during MEM of an SW -> mem_write drops immediately, no pc_write or reg_write, restart via IDLE.
